// File: rtl/car_detector_pkg.sv
// car_detector_pkg
// Shared types for the parking-lot gate detector.
//   det_state_t  : 3-bit FSM state encoding (also driven onto state_dbg)
//   S_IDLE_BEAMS : conditioned beam pair {a, b} when neither beam is blocked
//   next_state() : beam-sequence transition table, before the stall timeout is applied
package car_detector_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EN_A  = 3'd1,
        ST_EN_AB = 3'd2,
        ST_EN_B  = 3'd3,
        ST_EX_B  = 3'd4,
        ST_EX_AB = 3'd5,
        ST_EX_A  = 3'd6,
        ST_FAULT = 3'd7
    } det_state_t;

    localparam logic [1:0] S_IDLE_BEAMS = 2'b00;

    // s is {a, b}. The exit path is the entry path with A and B swapped.
    // Any beam pair that has no listed transition holds the current state.
    function automatic det_state_t next_state(input det_state_t cur, input logic [1:0] s);
        det_state_t nxt;
        nxt = cur;
        case (cur)
            ST_IDLE: begin
                case (s)
                    2'b10:   nxt = ST_EN_A;
                    2'b01:   nxt = ST_EX_B;
                    2'b11:   nxt = ST_FAULT;   // both beams at once: no legal origin
                    default: nxt = ST_IDLE;
                endcase
            end
            ST_EN_A: begin
                case (s)
                    2'b11:   nxt = ST_EN_AB;
                    2'b00:   nxt = ST_IDLE;    // car backed out
                    2'b01:   nxt = ST_FAULT;
                    default: nxt = ST_EN_A;
                endcase
            end
            ST_EN_AB: begin
                case (s)
                    2'b01:   nxt = ST_EN_B;
                    2'b10:   nxt = ST_EN_A;
                    2'b00:   nxt = ST_FAULT;
                    default: nxt = ST_EN_AB;
                endcase
            end
            ST_EN_B: begin
                case (s)
                    2'b00:   nxt = ST_IDLE;    // entry complete
                    2'b11:   nxt = ST_EN_AB;
                    2'b10:   nxt = ST_FAULT;
                    default: nxt = ST_EN_B;
                endcase
            end
            ST_EX_B: begin
                case (s)
                    2'b11:   nxt = ST_EX_AB;
                    2'b00:   nxt = ST_IDLE;    // car backed out
                    2'b10:   nxt = ST_FAULT;
                    default: nxt = ST_EX_B;
                endcase
            end
            ST_EX_AB: begin
                case (s)
                    2'b10:   nxt = ST_EX_A;
                    2'b01:   nxt = ST_EX_B;
                    2'b00:   nxt = ST_FAULT;
                    default: nxt = ST_EX_AB;
                endcase
            end
            ST_EX_A: begin
                case (s)
                    2'b00:   nxt = ST_IDLE;    // exit complete
                    2'b11:   nxt = ST_EX_AB;
                    2'b01:   nxt = ST_FAULT;
                    default: nxt = ST_EX_A;
                endcase
            end
            default: begin
                // FAULT only releases once the gate is completely clear, so a
                // beam still blocked cannot start a new sequence mid-car.
                if (s == S_IDLE_BEAMS) nxt = ST_IDLE;
                else                   nxt = ST_FAULT;
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/car_detector_sensor_cond.sv
// car_detector_sensor_cond
// Conditions one raw photo-beam input: a 2-flop synchronizer, optionally
// followed by a debounce filter when CAR_DETECTOR_DEBOUNCE_EN is defined.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   raw   : asynchronous beam input, 1 = blocked
//   clean : conditioned beam level
// Macro CAR_DETECTOR_DEBOUNCE_EN: clean follows the synchronized level only
// after it has differed from clean for DEBOUNCE_CYCLES consecutive cycles.
// Without it, clean is the synchronizer output and DEBOUNCE_CYCLES is unused.
module car_detector_sensor_cond #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], raw};
    end

`ifdef CAR_DETECTOR_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_q;
    logic            clean_q;

    // Count consecutive cycles of disagreement; any bounce back to the
    // accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q <= '0;
            clean_q  <= 1'b0;
        end else if (sync_q[1] != clean_q) begin
            if (db_cnt_q == DB_LAST) begin
                clean_q  <= sync_q[1];
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end else begin
            db_cnt_q <= '0;
        end
    end

    assign clean = clean_q;
`else
    assign clean = sync_q[1];
`endif

endmodule

// File: rtl/car_detector.sv
// car_detector
// Parking-lot gate detector feeding the occupancy counter. Tracks a car
// through outer beam A and inner beam B and pulses inc/dec only on complete
// legal sequences; illegal sequences and stalls raise a fault pulse.
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   a_raw     : outer beam, asynchronous, 1 = blocked
//   b_raw     : inner beam, asynchronous, 1 = blocked
//   inc       : one-cycle pulse, car fully entered
//   dec       : one-cycle pulse, car fully exited
//   fault     : one-cycle pulse on entry to FAULT
//   busy      : high whenever the FSM is not IDLE
//   state_dbg : current FSM state encoding
// Macro CAR_DETECTOR_DEBOUNCE_EN enables per-beam debounce (DEBOUNCE_CYCLES).
module car_detector #(
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_raw,
    input  logic       b_raw,
    output logic       inc,
    output logic       dec,
    output logic       fault,
    output logic       busy,
    output logic [2:0] state_dbg
);
    import car_detector_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic a_s;
    logic b_s;

    car_detector_sensor_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_a (
        .clk   (clk),
        .reset (reset),
        .raw   (a_raw),
        .clean (a_s)
    );

    car_detector_sensor_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_b (
        .clk   (clk),
        .reset (reset),
        .raw   (b_raw),
        .clean (b_s)
    );

    det_state_t       state_q;
    det_state_t       state_d;
    det_state_t       step_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timed_out;
    logic             inc_q;
    logic             dec_q;
    logic             fault_q;

    always_comb begin
        step_d    = next_state(state_q, {a_s, b_s});
        // A sequence that sits in one in-progress state too long is a stall.
        timed_out = (step_d == state_q) && (state_q != ST_IDLE) &&
                    (state_q != ST_FAULT) && (cnt_q == CNT_LAST);
        state_d   = timed_out ? ST_FAULT : step_d;

        cnt_d = cnt_q;
        if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_FAULT)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pulses are decoded from the transition being taken, so each event
    // fires exactly once and the three outputs cannot overlap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inc_q   <= (state_q == ST_EN_B) && (state_d == ST_IDLE);
            dec_q   <= (state_q == ST_EX_A) && (state_d == ST_IDLE);
            fault_q <= (state_q != ST_FAULT) && (state_d == ST_FAULT);
        end
    end

    assign inc       = inc_q;
    assign dec       = dec_q;
    assign fault     = fault_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule
